// File: rtl/cci_mpf_svc_vtp_pt_sw_ooo.sv
// Software page-table translation front end: requests are posted to a host ring,
// and responses complete out of order by slot id. CCI_MPF_VTP_PT_SW_WATCHDOG_EN adds the watchdog.
module cci_mpf_svc_vtp_pt_sw_ooo #(
  parameter int N_SLOTS        = 8,
  parameter int RING_ENTRIES   = 64,
  parameter int VA_IDX_BITS    = 36,
  parameter int PA_IDX_BITS    = 40,
  parameter int META_BITS      = 2,
  parameter int TAG_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_en,
  output logic                   req_rdy,
  input  logic [VA_IDX_BITS-1:0] req_va,
  input  logic [META_BITS-1:0]   req_meta,
  input  logic [TAG_BITS-1:0]    req_tag,
  output logic                   rsp_en,
  output logic [VA_IDX_BITS-1:0] rsp_va,
  output logic [PA_IDX_BITS-1:0] rsp_pa,
  output logic [META_BITS-1:0]   rsp_meta,
  output logic [TAG_BITS-1:0]    rsp_tag,
  output logic                   rsp_is_big_page,
  output logic                   rsp_not_present,
  output logic                   wr_en,
  output logic [57:0]            wr_addr,
  output logic [63:0]            wr_data,
  input  logic                   wr_rdy,
  input  logic                   buf_pa_valid,
  input  logic [57:0]            buf_pa,
  input  logic                   vtp_enabled,
  input  logic                   csr_rsp_valid,
  input  logic [63:0]            csr_rsp,
  output logic                   ev_busy,
  output logic                   ev_failed,
  output logic                   ev_stray,
  output logic                   ev_timeout,
  output logic [47:0]            last_vaddr
);
  localparam int SLOT_BITS = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int RING_BITS = $clog2(RING_ENTRIES);

  logic                       initialized;
  logic [57:RING_BITS]        ring_base;
  logic [RING_BITS-1:0]       ring_idx;
  logic [N_SLOTS-1:0]         busy;
  logic [N_SLOTS-1:0]         set_mask;
  logic [N_SLOTS-1:0]         clr_mask;
  logic [VA_IDX_BITS-1:0]     slot_va   [N_SLOTS];
  logic [META_BITS-1:0]       slot_meta [N_SLOTS];
  logic [TAG_BITS-1:0]        slot_tag  [N_SLOTS];

  logic                       csr_valid_q;
  logic                       csr_np_q;
  logic                       csr_big_q;
  logic [5:0]                 csr_slot_q;
  logic [PA_IDX_BITS-1:0]     csr_pa_q;

  logic                       have_free;
  logic [SLOT_BITS-1:0]       alloc_slot;
  logic [5:0]                 alloc_id;
  logic                       accept;
  logic [SLOT_BITS-1:0]       csr_idx;
  logic                       csr_hit;
  logic                       unused_bits;

  assign unused_bits = ^{buf_pa[RING_BITS-1:0], csr_rsp[63:PA_IDX_BITS+12], csr_rsp[11:8]};

  // Lowest-numbered free slot wins; scanning downward leaves the smallest index last.
  always_comb begin
    have_free  = 1'b0;
    alloc_slot = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        have_free  = 1'b1;
        alloc_slot = SLOT_BITS'(i);
      end
    end
  end

  assign alloc_id = 6'(alloc_slot);
  assign req_rdy  = initialized & vtp_enabled & wr_rdy & have_free;
  assign accept   = req_en & req_rdy;
  assign csr_idx  = csr_slot_q[SLOT_BITS-1:0];
  assign csr_hit  = csr_valid_q && (32'(csr_slot_q) < N_SLOTS) && busy[csr_idx];
  assign ev_busy  = |busy;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept) set_mask[alloc_slot] = 1'b1;
    if (csr_hit) clr_mask[csr_idx] = 1'b1;
  end

  // Per-slot request context needs no reset; the busy vector qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_va[alloc_slot]   <= req_va;
      slot_meta[alloc_slot] <= req_meta;
      slot_tag[alloc_slot]  <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      initialized     <= 1'b0;
      ring_base       <= '0;
      ring_idx        <= '0;
      busy            <= '0;
      csr_valid_q     <= 1'b0;
      csr_np_q        <= 1'b0;
      csr_big_q       <= 1'b0;
      csr_slot_q      <= '0;
      csr_pa_q        <= '0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      rsp_en          <= 1'b0;
      rsp_va          <= '0;
      rsp_pa          <= '0;
      rsp_meta        <= '0;
      rsp_tag         <= '0;
      rsp_is_big_page <= 1'b0;
      rsp_not_present <= 1'b0;
      ev_failed       <= 1'b0;
      ev_stray        <= 1'b0;
      last_vaddr      <= '0;
    end else begin
      csr_valid_q <= csr_rsp_valid;
      csr_np_q    <= csr_rsp[0];
      csr_big_q   <= csr_rsp[1];
      csr_slot_q  <= csr_rsp[7:2];
      csr_pa_q    <= csr_rsp[PA_IDX_BITS+11:12];
      busy        <= (busy & ~clr_mask) | set_mask;
      wr_en       <= accept;
      rsp_en      <= csr_hit;
      ev_failed   <= csr_hit & csr_np_q;
      ev_stray    <= csr_valid_q & ~csr_hit;
      if (accept) begin
        wr_addr    <= {ring_base, ring_idx};
        wr_data    <= 64'({req_va, 5'b0, alloc_id, 1'b1});
        last_vaddr <= 48'({req_va, 12'b0});
        ring_idx   <= ring_idx + 1'b1;
      end
      if (csr_hit) begin
        rsp_va          <= slot_va[csr_idx];
        rsp_meta        <= slot_meta[csr_idx];
        rsp_tag         <= slot_tag[csr_idx];
        rsp_pa          <= csr_pa_q;
        rsp_is_big_page <= csr_big_q;
        rsp_not_present <= csr_np_q;
      end
      // A new ring base restarts the ring even if a write was accepted this cycle.
      if (buf_pa_valid) begin
        initialized <= 1'b1;
        ring_base   <= buf_pa[57:RING_BITS];
        ring_idx    <= '0;
      end
    end
  end

`ifdef CCI_MPF_VTP_PT_SW_WATCHDOG_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_BITS-1:0] wd_count;
  logic               timeout_q;

  // Counts cycles with work outstanding but no host response; the flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (csr_rsp_valid || !ev_busy) begin
        wd_count <= '0;
      end else if (wd_count != WD_BITS'(TIMEOUT_CYCLES)) begin
        wd_count <= wd_count + 1'b1;
        if (wd_count == WD_BITS'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
      end
    end
  end

  assign ev_timeout = timeout_q;
`else
  assign ev_timeout = 1'b0;
`endif

endmodule
